// File: rtl/microsequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : microsequencer_pkg
// Description : Shared constants for the microsequencer and the microcode ROM.
//               Holds the microinstruction codes, the field widths and the
//               contents of the three fixed dispatch tables.
// Revision    : 1.0 - initial release
// ============================================================================
package microsequencer_pkg;

  localparam int STATE_W = 4;
  localparam int MICRO_W = 4;
  localparam int SYM_W   = 2;
  localparam int SEL_W   = 2;

  // Every code from 5 up is illegal and sends the sequencer back to start.
  typedef enum logic [MICRO_W-1:0] {
    OP_NEXT    = 4'd0,
    OP_DISP1   = 4'd1,
    OP_DISP2   = 4'd2,
    OP_DISP3   = 4'd3,
    OP_RESTART = 4'd4
  } micro_op_e;

  // Dispatch tables D1/D2/D3, selected by sel = 1/2/3 and indexed by sym.
  // sel = 0 is not a dispatch and returns state 0.
  function automatic logic [STATE_W-1:0] dispatch_target(
    input logic [SEL_W-1:0] sel,
    input logic [SYM_W-1:0] sym
  );
    logic [STATE_W-1:0] t;
    case ({sel, sym})
      4'b01_00: t = 4'd4;
      4'b01_01: t = 4'd5;
      4'b01_10: t = 4'd6;
      4'b01_11: t = 4'd10;
      4'b10_00: t = 4'd11;
      4'b10_01: t = 4'd12;
      4'b10_10: t = 4'd0;
      4'b10_11: t = 4'd0;
      4'b11_00: t = 4'd7;
      4'b11_01: t = 4'd8;
      4'b11_10: t = 4'd9;
      4'b11_11: t = 4'd0;
      default:  t = 4'd0;
    endcase
    return t;
  endfunction

endpackage
`default_nettype wire

// File: rtl/microsequencer_dispatch_rom.sv
`default_nettype none
// ============================================================================
// Module      : microsequencer_dispatch_rom
// Description : Combinational dispatch table lookup: table select plus input
//               symbol in, target state out.
// Revision    : 1.0 - initial release
// ============================================================================
module microsequencer_dispatch_rom
  import microsequencer_pkg::*;
(
  input  logic [SEL_W-1:0]   table_sel,
  input  logic [SYM_W-1:0]   sym,
  output logic [STATE_W-1:0] target
);

  // Pure table lookup; the contents live in the shared package.
  always_comb begin
    target = dispatch_target(table_sel, sym);
  end

endmodule
`default_nettype wire

// File: rtl/microsequencer.sv
`default_nettype none
// ============================================================================
// Module      : microsequencer
// Description : Next-state stage of the microprogrammed controller. Holds the
//               state register addressing the microcode ROM, decodes the
//               returned microinstruction and consumes input symbols through
//               a valid/ready handshake on dispatch steps.
// Revision    : 1.0 - initial release
// ============================================================================
module microsequencer
  import microsequencer_pkg::*;
#(
  parameter int                 CNT_W       = 8,
  parameter logic [STATE_W-1:0] START_STATE = 4'd0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [MICRO_W-1:0] micro_in,
  output logic [STATE_W-1:0] state,
  input  logic [SYM_W-1:0]   sym,
  input  logic               sym_valid,
  output logic               sym_ready,
  output logic               done,
  output logic               err,
  output logic [CNT_W-1:0]   sym_count
);

  logic [STATE_W-1:0] state_q, state_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   sym_count_q, sym_count_d;
  logic [STATE_W-1:0] disp_target;
  logic               is_dispatch;

  // The low two bits of a dispatch code (1/2/3) directly select the table.
  microsequencer_dispatch_rom u_dispatch_rom (
    .table_sel (micro_in[SEL_W-1:0]),
    .sym       (sym),
    .target    (disp_target)
  );

  // Decode the microinstruction into next state, flags and handshake.
  always_comb begin
    state_d     = state_q;
    done_d      = 1'b0;
    err_d       = err_q;
    sym_count_d = sym_count_q;
    is_dispatch = 1'b0;
    case (micro_in)
      OP_NEXT: begin
        state_d = state_q + 4'd1;
      end
      OP_DISP1, OP_DISP2, OP_DISP3: begin
        is_dispatch = 1'b1;
        // Without a valid symbol the step stalls with the state held.
        if (sym_valid) begin
          state_d = disp_target;
          if (sym_count_q != {CNT_W{1'b1}}) begin
            sym_count_d = sym_count_q + CNT_W'(1);
          end
        end
      end
      OP_RESTART: begin
        state_d = START_STATE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = START_STATE;
        err_d   = 1'b1;
      end
    endcase
    // Ready is suppressed under reset so a symbol offered then is not taken.
    sym_ready = is_dispatch & ~reset;
  end

  // State register, registered done pulse, sticky error and symbol counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= START_STATE;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      sym_count_q <= '0;
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      err_q       <= err_d;
      sym_count_q <= sym_count_d;
    end
  end

  assign state     = state_q;
  assign done      = done_q;
  assign err       = err_q;
  assign sym_count = sym_count_q;

endmodule
`default_nettype wire

// File: tb/tb_microsequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_microsequencer
// Description : Self-checking bench for microsequencer, wired to a copy of
//               the microcode ROM and compared against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_microsequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] micro_in;
  logic [3:0] state;
  logic [1:0] sym;
  logic       sym_valid;
  logic       sym_ready;
  logic       done;
  logic       err;
  logic [7:0] sym_count;

  logic       override_en;
  logic [3:0] override_val;

  int checks = 0;
  int errors = 0;

  // Microcode program: 0-2 NEXT, 3 DISP1, 4 NEXT, 5 DISP3, 6-9 NEXT,
  // 10 DISP2, 11-12 RESTART, 13-15 NEXT.
  logic [3:0] rom [16] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd0, 4'd3, 4'd0, 4'd0,
                           4'd0, 4'd0, 4'd2, 4'd4, 4'd4, 4'd0, 4'd0, 4'd0};
  int d1 [4] = '{4, 5, 6, 10};
  int d2 [4] = '{11, 12, 0, 0};
  int d3 [4] = '{7, 8, 9, 0};

  int m_state = 0;
  int m_count = 0;
  int m_done  = 0;
  int m_err   = 0;

  assign micro_in = override_en ? override_val : rom[state];

  always #5 clk = ~clk;

  microsequencer #(.CNT_W(8), .START_STATE(4'd0)) dut (
    .clk       (clk),
    .reset     (reset),
    .micro_in  (micro_in),
    .state     (state),
    .sym       (sym),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .done      (done),
    .err       (err),
    .sym_count (sym_count)
  );

  function automatic int model_op();
    return override_en ? int'(override_val) : int'(rom[m_state]);
  endfunction

  function automatic bit model_ready();
    int op;
    op = model_op();
    return (!reset) && (op >= 1) && (op <= 3);
  endfunction

  // Apply one clock edge of the specification's rules to the model, then
  // let the DUT take the same edge and settle.
  task automatic tick();
    int op;
    op = model_op();
    if (reset) begin
      m_state = 0; m_count = 0; m_done = 0; m_err = 0;
    end else begin
      m_done = 0;
      if (op == 0) begin
        m_state = (m_state + 1) % 16;
      end else if (op >= 1 && op <= 3) begin
        if (sym_valid) begin
          if (op == 1)      m_state = d1[sym];
          else if (op == 2) m_state = d2[sym];
          else              m_state = d3[sym];
          if (m_count < 255) m_count = m_count + 1;
        end
      end else if (op == 4) begin
        m_state = 0;
        m_done  = 1;
      end else begin
        m_state = 0;
        m_err   = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; sym_valid = 1'b0; sym = 2'd0;
    override_en = 1'b0; override_val = 4'd0;
    tick(); tick();
    checks++;
    if (sym_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b want 0", sym_ready);
    end
    reset = 1'b0;
    checks++;
    if (state !== 4'd0 || done !== 1'b0 || err !== 1'b0 || sym_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_values: state=%0d done=%b err=%b cnt=%0d want 0/0/0/0",
               state, done, err, sym_count);
    end
  endtask

  task automatic test_next_and_stall();
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (state !== 4'(i)) begin
        errors++; $display("FAIL next_step: got %0d want %0d", state, i);
      end
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (sym_ready !== 1'b1) begin
        errors++; $display("FAIL stall_ready: got %b want 1", sym_ready);
      end
      tick();
      checks++;
      if (state !== 4'd3 || sym_count !== 8'd0) begin
        errors++; $display("FAIL stall_hold: state=%0d cnt=%0d want 3/0", state, sym_count);
      end
    end
  endtask

  task automatic test_dispatch_restart();
    sym = 2'd2; sym_valid = 1'b1;
    tick();
    sym_valid = 1'b0;
    checks++;
    if (state !== 4'd6 || sym_count !== 8'd1) begin
      errors++; $display("FAIL disp1: state=%0d cnt=%0d want 6/1", state, sym_count);
    end
    for (int i = 7; i <= 10; i++) begin
      tick();
      checks++;
      if (state !== 4'(i)) begin
        errors++; $display("FAIL next_after_disp: got %0d want %0d", state, i);
      end
    end
    sym = 2'd1; sym_valid = 1'b1;
    tick();
    sym_valid = 1'b0;
    checks++;
    if (state !== 4'd12 || sym_ready !== 1'b0) begin
      errors++; $display("FAIL disp2: state=%0d ready=%b want 12/0", state, sym_ready);
    end
    tick();
    checks++;
    if (state !== 4'd0 || done !== 1'b1 || sym_count !== 8'd2) begin
      errors++;
      $display("FAIL restart: state=%0d done=%b cnt=%0d want 0/1/2", state, done, sym_count);
    end
    tick();
    checks++;
    if (done !== 1'b0 || state !== 4'd1) begin
      errors++; $display("FAIL done_pulse: done=%b state=%0d want 0/1", done, state);
    end
  endtask

  task automatic test_valid_held();
    reset = 1'b1; tick(); reset = 1'b0;
    sym = 2'd1; sym_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (state !== 4'(i) || sym_count !== 8'd0) begin
        errors++;
        $display("FAIL held_valid_next: state=%0d cnt=%0d want %0d/0", state, sym_count, i);
      end
    end
    tick();
    checks++;
    if (state !== 4'd5 || sym_count !== 8'd1) begin
      errors++; $display("FAIL held_disp1: state=%0d cnt=%0d want 5/1", state, sym_count);
    end
    sym = 2'd0;
    tick();
    sym_valid = 1'b0;
    checks++;
    if (state !== 4'd7 || sym_count !== 8'd2) begin
      errors++; $display("FAIL held_disp3: state=%0d cnt=%0d want 7/2", state, sym_count);
    end
  endtask

  task automatic test_illegal();
    reset = 1'b1; tick(); reset = 1'b0;
    tick(); tick(); tick();
    sym = 2'd2; sym_valid = 1'b1; tick(); sym_valid = 1'b0;
    override_en = 1'b1; override_val = 4'd9;
    checks++;
    if (state !== 4'd6 || sym_ready !== 1'b0) begin
      errors++; $display("FAIL illegal_setup: state=%0d ready=%b want 6/0", state, sym_ready);
    end
    sym_valid = 1'b1;
    tick();
    sym_valid = 1'b0;
    override_en = 1'b0;
    checks++;
    if (state !== 4'd0 || err !== 1'b1 || done !== 1'b0 || sym_count !== 8'd1) begin
      errors++;
      $display("FAIL illegal: state=%0d err=%b done=%b cnt=%0d want 0/1/0/1",
               state, err, done, sym_count);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (err !== 1'b1 || state !== 4'(i + 1)) begin
        errors++; $display("FAIL err_sticky: err=%b state=%0d want 1/%0d", err, state, i + 1);
      end
    end
    reset = 1'b1; tick(); reset = 1'b0;
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL err_clear: got %b want 0", err);
    end
  endtask

  task automatic test_reset_mid_stall();
    tick(); tick(); tick();
    sym = 2'd3; sym_valid = 1'b1; tick();
    sym = 2'd2; tick();
    sym_valid = 1'b0;
    tick(); tick(); tick(); tick();
    checks++;
    if (state !== 4'd3 || sym_count !== 8'd2) begin
      errors++; $display("FAIL stall_setup: state=%0d cnt=%0d want 3/2", state, sym_count);
    end
    reset = 1'b1; sym = 2'd0; sym_valid = 1'b1;
    tick();
    reset = 1'b0; sym_valid = 1'b0;
    checks++;
    if (state !== 4'd0 || sym_count !== 8'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_stall: state=%0d cnt=%0d done=%b want 0/0/0",
               state, sym_count, done);
    end
  endtask

  task automatic test_saturation();
    int cycles;
    reset = 1'b1; tick(); reset = 1'b0;
    sym = 2'd0; sym_valid = 1'b1;
    cycles = 0;
    while (m_count < 255 && cycles < 2000) begin
      tick();
      cycles++;
    end
    for (int i = 0; i < 30; i++) tick();
    sym_valid = 1'b0;
    checks++;
    if (sym_count !== 8'hFF || m_count != 255) begin
      errors++; $display("FAIL saturation: got %0d want 255", sym_count);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset        = ($urandom_range(0, 31) == 0);
      sym          = 2'($urandom_range(0, 3));
      sym_valid    = ($urandom_range(0, 2) != 0);
      override_en  = ($urandom_range(0, 19) == 0);
      override_val = 4'($urandom_range(0, 15));
      #1;
      checks++;
      if (sym_ready !== model_ready()) begin
        errors++; $display("FAIL rand_ready: got %b want %b", sym_ready, model_ready());
      end
      tick();
      checks++;
      if (state !== 4'(m_state) || sym_count !== 8'(m_count) ||
          done !== 1'(m_done) || err !== 1'(m_err)) begin
        errors++;
        $display("FAIL rand_state: st=%0d cnt=%0d done=%b err=%b want %0d/%0d/%0d/%0d",
                 state, sym_count, done, err, m_state, m_count, m_done, m_err);
      end
    end
    reset = 1'b0; override_en = 1'b0; sym_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_next_and_stall();
    test_dispatch_restart();
    test_valid_held();
    test_illegal();
    test_reset_mid_stall();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/microsequencer.md
Name: microsequencer

Overview:
- Next-state stage of the microprogrammed controller; sits directly upstream of the microcode ROM.
- Holds the 4-bit state register that addresses the ROM and receives the ROM's 4-bit microinstruction back combinationally in the same cycle.
- Decodes the microinstruction to pick the next state: sequential increment, dispatch through one of three fixed dispatch tables indexed by an input symbol, or restart.
- Consumes input symbols through a valid/ready handshake; stalls on a dispatch step until a symbol arrives.

Parameters:
- CNT_W, 8, width of the saturating consumed-symbol counter.
- START_STATE, 0, state loaded on reset and on RESTART/illegal microinstruction.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- micro_in  input  4  microinstruction returned by the microcode ROM for the current state.
- state  output  4  current state register; drives the ROM address.
- sym  input  2  input symbol used as dispatch-table index.
- sym_valid  input  1  sym is valid this cycle.
- sym_ready  output  1  sequencer will consume sym this cycle if sym_valid.
- done  output  1  one-cycle pulse after a RESTART executes.
- err  output  1  sticky illegal-microinstruction flag.
- sym_count  output  CNT_W  number of symbols consumed, saturating.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on reset.
- Reset values: state=START_STATE, done=0, err=0, sym_count=0. sym_ready=0 while reset is high.
- Microinstruction encoding:
  - 0 NEXT: state+1, mod 16; 15 wraps to 0.
  - 1 DISP1: state=D1[sym].
  - 2 DISP2: state=D2[sym].
  - 3 DISP3: state=D3[sym].
  - 4 RESTART: state=START_STATE.
  - 5..15 and any unknown/default: ILLEGAL.
- Dispatch tables, index 0..3:
  - D1 = {4,5,6,10}
  - D2 = {11,12,0,0}
  - D3 = {7,8,9,0}
- sym_ready is combinational: 1 exactly when micro_in is 1, 2 or 3 and reset=0.
- Handshake and stall:
  - A dispatch advances only on a cycle with sym_valid && sym_ready. That cycle consumes sym and sets sym_count+=1, saturating at 2^CNT_W-1.
  - On a dispatch step with sym_valid=0, state holds and nothing is consumed; the stall length is unbounded.
  - Holding sym_valid high across NEXT/RESTART cycles does not consume the symbol; it waits for the next dispatch.
- Latency: every non-stalled microinstruction takes exactly one cycle; state updates on the edge ending the cycle.
- done: registered. It is 1 in the cycle after the edge on which a RESTART executed, otherwise 0. Back-to-back RESTARTs give done high on consecutive cycles.
- ILLEGAL: state=START_STATE, err set to 1 and held until reset, no symbol consumed, done not asserted.
- Precedence:
  - reset overrides everything, including a simultaneous handshake.
  - A symbol presented in the same cycle that reset is high is not consumed and not counted.
- Reset mid-stall returns to START_STATE with the counter cleared.

Decomposition:
- Shared package, common with the microcode ROM:
  - microinstruction code constants (NEXT, DISP1, DISP2, DISP3, RESTART);
  - state and microinstruction width constants;
  - dispatch table contents D1/D2/D3 as constant functions or arrays.
- One natural sub-module: dispatch_rom. It is combinational: 2-bit table select plus 2-bit sym in, 4-bit target state out.
- Sequencer control, counter and flags stay in microsequencer.

Test Plan:
- Bench wires the sequencer to the team's microcode ROM (state->address, microinstruction->micro_in) for all scenarios except the illegal-code one.
- Reset, then run with sym_valid=0 -> state goes 0,1,2,3 on successive edges, then holds at 3 with sym_ready=1 for 5 cycles; sym_count=0.
- At state 3, drive sym=2, sym_valid=1 for one cycle -> state=6, sym_count=1. NEXT steps then give 7,8,9,10.
- At state 10, sym=1 valid -> state=12. RESTART at 12 -> state=0 next edge, done=1 for exactly one cycle, sym_count=2.
- Path 0..3, sym=1 at state 3 -> state=5. DISP3 at state 5 with sym=0 -> state=7. sym_valid held high during the NEXT cycles at 0..2 -> sym_count increments only on the dispatch edges.
- Bench drives micro_in=9 directly at state 6 -> state=0, err=1 and stays 1 across later legal steps; reset clears err. Reset asserted during a DISP1 stall with sym_valid=1 -> state=0, sym_count=0, no consumption.
